// File: rtl/reg_file.sv
// 2**Addr_Bits x Bits register file with register 0 hard-wired to zero.
// It has one synchronous write port, two combinational read ports with optional write bypass, and a debug read port.
module reg_file #(
    parameter int Bits      = 32,
    parameter int Addr_Bits = 5,
    parameter bit BYPASS    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [Addr_Bits-1:0] wa,
    input  logic [Bits-1:0]      wd,
    input  logic [Addr_Bits-1:0] ra1,
    input  logic [Addr_Bits-1:0] ra2,
    output logic [Bits-1:0]      rd1,
    output logic [Bits-1:0]      rd2,
    input  logic [Addr_Bits-1:0] dbg_addr,
    output logic [Bits-1:0]      dbg_data
);

    localparam int Depth = 2 ** Addr_Bits;

    // Entry 0 has no storage; it is produced as a constant on every read.
    logic [Bits-1:0] regs_q [1:Depth-1];
    logic            wr_fire;

    assign wr_fire = we && !rst && (wa != '0);

    // NOTE: every entry must clear asynchronously, so the array is built from resettable flops rather than an inferred RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < Depth; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_fire) begin
            regs_q[wa] <= wd;
        end
    end

    function automatic logic [Bits-1:0] stored(input logic [Addr_Bits-1:0] a);
        return (a == '0) ? '0 : regs_q[a];
    endfunction

    // Forwarding is disabled during reset, so every port reads 0 while rst is high.
    always_comb begin
        rd1      = stored(ra1);
        rd2      = stored(ra2);
        dbg_data = stored(dbg_addr);
        if (BYPASS && wr_fire && (ra1 == wa)) rd1 = wd;
        if (BYPASS && wr_fire && (ra2 == wa)) rd2 = wd;
    end

endmodule

// File: tb/tb_reg_file.sv
// Randomized and directed bench for reg_file; both BYPASS variants are driven in parallel and checked against an array model.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  wa, ra1, ra2, dbg_addr;
    logic [31:0] wd;
    logic [31:0] rd1_0, rd2_0, dbg_0, rd1_1, rd2_1, dbg_1;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [32];

    always #5 clk = ~clk;

    reg_file #(.Bits(32), .Addr_Bits(5), .BYPASS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_0), .rd2(rd2_0),
        .dbg_addr(dbg_addr), .dbg_data(dbg_0)
    );

    reg_file #(.Bits(32), .Addr_Bits(5), .BYPASS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_1), .rd2(rd2_1),
        .dbg_addr(dbg_addr), .dbg_data(dbg_1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_stored(input logic [4:0] a);
        return (rst || a == 5'd0) ? 32'd0 : mem[a];
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input bit byp);
        if (byp && !rst && we && wa != 5'd0 && a == wa) return wd;
        return model_stored(a);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    endtask

    task automatic check_reads(input string tag);
        check({tag, "_rd1_b0"}, rd1_0, model_read(ra1, 1'b0));
        check({tag, "_rd2_b0"}, rd2_0, model_read(ra2, 1'b0));
        check({tag, "_rd1_b1"}, rd1_1, model_read(ra1, 1'b1));
        check({tag, "_rd2_b1"}, rd2_1, model_read(ra2, 1'b1));
        check({tag, "_dbg_b0"}, dbg_0, model_stored(dbg_addr));
        check({tag, "_dbg_b1"}, dbg_1, model_stored(dbg_addr));
    endtask

    // Inputs are already applied; check just before and just after the next rising edge.
    task automatic step(input string tag);
        #1;
        check_reads({tag, "_pre"});
        @(posedge clk);
        if (!rst && we && wa != 5'd0) mem[wa] = wd;
        #1;
        check_reads({tag, "_post"});
    endtask

    task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg);
        we = w; wa = a; wd = d; ra1 = r1; ra2 = r2; dbg_addr = dbg;
    endtask

    initial begin
        clear_model();
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        #2;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i); dbg_addr = 5'(i);
            #1;
            check_reads("reset_sweep");
        end

        // Release reset exactly on an edge that carries a write to r3.
        @(negedge clk);
        drive(1'b1, 5'd3, 32'h7, 5'd1, 5'd2, 5'd3);
        @(posedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_r3_b0", 32'((dbg_0 === 32'd0) || (dbg_0 === 32'h7)), 32'd1);
        check("rst_release_r3_b1", 32'((dbg_1 === 32'd0) || (dbg_1 === 32'h7)), 32'd1);
        @(posedge clk);
        mem[3] = 32'h7;
        #1;
        check("rst_release_next_b0", dbg_0, 32'h7);
        check("rst_release_next_b1", dbg_1, 32'h7);

        // An asynchronous reset in the middle of a write cycle loses that write.
        @(negedge clk);
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5);
        step("write_r5");
        @(negedge clk);
        #2;
        rst = 1'b1;
        clear_model();
        #1;
        check("mid_reset_dbg_b0", dbg_0, 32'd0);
        check("mid_reset_dbg_b1", dbg_1, 32'd0);
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(i);
            #0.1;
            check_reads("mid_reset_sweep");
        end
        ra1 = 5'd5; ra2 = 5'd5;
        @(posedge clk);
        #1;
        check_reads("reset_holds_write");
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5);
        #1;
        check_reads("after_reset_r5");

        // Plain write, then a we=0 cycle that must not disturb r8.
        @(negedge clk);
        drive(1'b1, 5'd8, 32'h1234_5678, 5'd8, 5'd8, 5'd8);
        step("write_r8");
        @(negedge clk);
        drive(1'b0, 5'd8, 32'hFFFF_FFFF, 5'd8, 5'd8, 5'd8);
        step("we0_r8");

        // Writes to r0 are discarded.
        @(negedge clk);
        drive(1'b1, 5'd0, 32'hAAAA_AAAA, 5'd0, 5'd0, 5'd0);
        step("write_r0");

        // Read-during-write on r9 for both bypass variants.
        @(negedge clk);
        drive(1'b1, 5'd9, 32'h1, 5'd0, 5'd0, 5'd9);
        step("r9_init");
        @(negedge clk);
        drive(1'b1, 5'd9, 32'h2, 5'd9, 5'd9, 5'd9);
        #1;
        check("rdw_before_b0", rd1_0, 32'h1);
        check("rdw_before_b1", rd1_1, 32'h2);
        check("rdw_dbg_before_b1", dbg_1, 32'h1);
        step("rdw_r9");
        check("rdw_after_b0", rd1_0, 32'h2);

        // Fill r1..r31 with 0x100+i, then sweep all three ports.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            drive(1'b1, 5'(i), 32'h100 + 32'(i), 5'(i), 5'(31 - i), 5'(i));
            step("fill");
        end
        @(negedge clk);
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i); ra1 = 5'(31 - i); ra2 = 5'(31 - i);
            #1;
            check("sweep_dbg", dbg_0, (i == 0) ? 32'd0 : 32'h100 + 32'(i));
            check("sweep_rd1", rd1_1, (i == 31) ? 32'd0 : 32'h100 + 32'(31 - i));
            check_reads("sweep");
        end

        // Random traffic with occasional mid-cycle resets.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom,
                  5'($urandom), 5'($urandom), 5'($urandom));
            if ($urandom_range(0, 3) == 0) ra1 = wa;
            if ($urandom_range(0, 3) == 0) ra2 = wa;
            if ($urandom_range(0, 7) == 0) wa = 5'd0;
            rst = 1'b0;
            if ($urandom_range(0, 49) == 0) begin
                #1;
                rst = 1'b1;
                clear_model();
            end
            step("random");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
